imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program as a big-endian byte stream,

---
 rtl/imem_pkg.sv | 17 +
 rtl/word_packer.sv | 36 +++
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Imported by the loader top and its byte-packing sub-module.
package imem_pkg;

   localparam int ADDR_W         = 8;
   localparam int DEPTH          = 256;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

endpackage : imem_pkg

// File: rtl/word_packer.sv
// Packs a big-endian byte stream into 32-bit words: the first byte pushed
// ends up in the most significant byte once four bytes have arrived.
module word_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0] byte_idx;

   // Flags the push that completes a word, so the caller can act in the same cycle.
   assign word_full = push && (byte_idx == LAST_IDX);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make the shift order-dependent.
   always_ff @(posedge clk) begin
      if (reset) begin
         word     <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (push) begin
         word     <= {word[WORD_W-9:0], byte_in};
         byte_idx <= byte_idx + 2'd1;
      end
   end

endmodule : word_packer

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes into words, writes them from a base
// address with wrap-around, and holds the CPU off memory while loading.
module imem_loader #(
   parameter int ADDR_W = imem_pkg::ADDR_W,
   parameter int DEPTH  = imem_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   import imem_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] word_cnt;
   logic [ADDR_W:0]   count_q;
   logic              push;
   logic              word_full;
   logic              last_word;
   logic              start_bad;
   logic              start_empty;
   logic              start_ok;

   assign start_bad   = start && (word_count > DEPTH_W);
   assign start_empty = start && (word_count == '0);
   assign start_ok    = (state == IDLE) && start && !start_bad && !start_empty;
   assign last_word   = ({1'b0, word_cnt} == (count_q - 1'b1));
   assign push        = byte_valid && byte_ready;

   word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok),
      .push      (push),
      .byte_in   (byte_in),
      .word      (wr_data),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start && !start_bad) state_next = start_empty ? DONE : RECV;
         end
         RECV:    if (word_full) state_next = WRITE;
         WRITE:   state_next = last_word ? DONE : RECV;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes decode straight from state, so byte_valid never reaches byte_ready.
   always_comb begin
      byte_ready = (state == RECV);
      wr_en      = (state == WRITE);
      cpu_hold   = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q   <= '0;
         count_q  <= '0;
         word_cnt <= '0;
         wr_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
         error <= (state == IDLE) && start_bad;
         if (start_ok) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            word_cnt <= '0;
         end
         // Address is computed as the word completes so it is ready in WRITE; it wraps mod DEPTH.
         if (word_full) wr_addr <= base_q + word_cnt;
         if ((state == WRITE) && !last_word) word_cnt <= word_cnt + 1'b1;
      end
   end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams compared against
// an address/word model computed from base, count and the big-endian byte list.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  word_count;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   imem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         start_cyc;
   int         err_n;
   int         busy_n;
   wr_t        wq[$];
   int         dq[$];
   logic [7:0] stream[$];
   logic       hold_log [65536];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs mid-cycle, away from the active edge.
   always @(negedge clk) begin
      hold_log[cyc & 16'hFFFF] = cpu_hold;
      if (!reset) begin
         if (wr_en) wq.push_back('{addr: wr_addr, data: wr_data, cyc: cyc});
         if (done) dq.push_back(cyc);
         if (error) err_n++;
         if (busy) busy_n++;
      end
   end

   task automatic clear_logs();
      wq.delete();
      dq.delete();
      err_n  = 0;
      busy_n = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0;
      base_addr = '0; word_count = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_logs();
   endtask

   task automatic begin_load(input logic [7:0] base, input logic [8:0] count);
      start = 1'b1; base_addr = base; word_count = count;
      @(posedge clk);
      #1 start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic make_stream(input int words);
      stream.delete();
      for (int i = 0; i < 4 * words; i++) stream.push_back(8'($urandom));
   endtask

   // Offers each byte until accepted; start_at >= 0 pulses a junk start alongside that byte.
   task automatic send_stream(input int gap_max, input int start_at);
      for (int i = 0; i < stream.size(); i++) begin
         int  budget = 0;
         logic acc;
         if (gap_max > 0) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
         end
         byte_valid = 1'b1;
         byte_in    = stream[i];
         if (i == start_at) begin
            start = 1'b1; base_addr = 8'hAA; word_count = 9'd1;
         end
         forever begin
            acc = byte_ready;
            @(posedge clk);
            #1 start = 1'b0;
            if (acc) break;
            budget++;
            if (budget > 100) begin
               miscompares++;
               $display("FAIL byte_accept: byte %0d not accepted within 100 cycles, required acceptance", i);
               byte_valid = 1'b0;
               return;
            end
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (dq.size() == 0 && k < budget) begin @(negedge clk); k++; end
      vectors++;
      if (dq.size() == 0) begin
         miscompares++;
         $display("FAIL done_wait: no done within %0d cycles, required one pulse", budget);
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   function automatic logic [7:0] exp_addr(input int base, input int i);
      return 8'((base + i) % 256);
   endfunction

   function automatic logic [31:0] exp_word(input int i);
      return {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
   endfunction

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vectors++;
      if ({byte_ready, wr_en, cpu_hold, busy, done, error, wr_addr, wr_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
                  byte_ready, wr_en, cpu_hold, busy, done, error, wr_addr, wr_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      clear_logs();
      stream = '{8'h8C, 8'h01, 8'h00, 8'h00};
      begin_load(8'd0, 9'd1);
      send_stream(0, -1);
      wait_done(20);
      vectors++;
      if (wq.size() !== 1) begin
         miscompares++;
         $display("FAIL single_count: got %0d writes, required 1", wq.size());
      end else begin
         vectors++;
         if (wq[0].addr !== 8'd0 || wq[0].data !== 32'h8C010000) begin
            miscompares++;
            $display("FAIL single_write: got addr=%h data=%h, required addr=00 data=8c010000", wq[0].addr, wq[0].data);
         end
         vectors++;
         if (dq.size() == 0 || dq[0] !== wq[0].cyc + 1) begin
            miscompares++;
            $display("FAIL single_done_timing: done at %0d, required %0d", dq.size() ? dq[0] : -1, wq[0].cyc + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      clear_logs();
      make_stream(2);
      begin_load(8'd8, 9'd2);
      send_stream(0, -1);
      wait_done(20);
      vectors++;
      if (wq.size() !== 2) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d writes, required 2", wq.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wq[i].addr !== exp_addr(8, i) || wq[i].data !== exp_word(i)) begin
               miscompares++;
               $display("FAIL b2b_write%0d: got addr=%h data=%h, required addr=%h data=%h",
                        i, wq[i].addr, wq[i].data, exp_addr(8, i), exp_word(i));
            end
         end
         vectors++;
         if (wq[1].cyc - wq[0].cyc !== 5) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, required 5", wq[1].cyc - wq[0].cyc);
         end
      end
      if (dq.size() > 0) begin
         for (int c = start_cyc; c <= dq[0]; c++) if (hold_log[c & 16'hFFFF] !== 1'b1) bad++;
         vectors++;
         if (bad != 0 || hold_log[(start_cyc - 1) & 16'hFFFF] !== 1'b0 || hold_log[(dq[0] + 1) & 16'hFFFF] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_cpu_hold: %0d low cycles in window, before=%b after=%b, required 0/0/0",
                     bad, hold_log[(start_cyc - 1) & 16'hFFFF], hold_log[(dq[0] + 1) & 16'hFFFF]);
         end
      end
   endtask

   task automatic test_wrap();
      clear_logs();
      make_stream(2);
      begin_load(8'd255, 9'd2);
      send_stream(1, -1);
      wait_done(20);
      vectors++;
      if (wq.size() !== 2 || wq[0].addr !== 8'd255 || wq[1].addr !== 8'd0 ||
          wq[0].data !== exp_word(0) || wq[1].data !== exp_word(1)) begin
         miscompares++;
         $display("FAIL wrap: got %0d writes first_addr=%h second_addr=%h, required 2 writes at ff then 00 with stream data",
                  wq.size(), wq.size() > 0 ? wq[0].addr : 8'hxx, wq.size() > 1 ? wq[1].addr : 8'hxx);
      end
   endtask

   task automatic test_zero_and_overflow();
      clear_logs();
      begin_load(8'd17, 9'd0);
      repeat (6) begin @(posedge clk); #1; end
      vectors++;
      if (dq.size() !== 1 || dq[0] !== start_cyc || wq.size() !== 0) begin
         miscompares++;
         $display("FAIL zero_count: got %0d done (first at %0d) and %0d writes, required 1 done at %0d and 0 writes",
                  dq.size(), dq.size() ? dq[0] : -1, wq.size(), start_cyc);
      end
      clear_logs();
      begin_load(8'd3, 9'd257);
      repeat (6) begin @(posedge clk); #1; end
      vectors++;
      if (err_n !== 1 || busy_n !== 0 || dq.size() !== 0 || wq.size() !== 0) begin
         miscompares++;
         $display("FAIL overflow_count: got error_cycles=%0d busy_cycles=%0d done=%0d writes=%0d, required 1/0/0/0",
                  err_n, busy_n, dq.size(), wq.size());
      end
   endtask

   task automatic test_full_depth();
      int bad = 0;
      int base = $urandom_range(255, 0);
      clear_logs();
      make_stream(256);
      begin_load(8'(base), 9'd256);
      send_stream(0, -1);
      wait_done(20);
      vectors++;
      if (wq.size() !== 256) begin
         miscompares++;
         $display("FAIL full_depth_count: got %0d writes, required 256", wq.size());
      end else begin
         for (int i = 0; i < 256; i++)
            if (wq[i].addr !== exp_addr(base, i) || wq[i].data !== exp_word(i)) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("FAIL full_depth_data: got %0d wrong writes, required 0", bad);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      clear_logs();
      stream = '{8'h11, 8'h22};
      begin_load(8'd40, 9'd1);
      send_stream(0, -1);
      do_reset();
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      vectors++;
      if (wq.size() !== 0 || {byte_ready, wr_en, cpu_hold, busy, done, wr_addr, wr_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_load: got writes=%0d rdy=%b hold=%b busy=%b addr=%h data=%h, required all 0",
                  wq.size(), byte_ready, cpu_hold, busy, wr_addr, wr_data);
      end
      @(posedge clk); #1;
      clear_logs();
      make_stream(1);
      begin_load(8'd41, 9'd1);
      send_stream(0, -1);
      wait_done(20);
      vectors++;
      if (wq.size() !== 1 || wq[0].addr !== 8'd41 || wq[0].data !== exp_word(0)) begin
         miscompares++;
         $display("FAIL reload_after_reset: got %0d writes addr=%h data=%h, required 1 write addr=29 data=%h",
                  wq.size(), wq.size() ? wq[0].addr : 8'hxx, wq.size() ? wq[0].data : 32'hx, exp_word(0));
      end
   endtask

   task automatic test_random_gaps();
      for (int it = 0; it < 6; it++) begin
         int base  = $urandom_range(255, 0);
         int words = $urandom_range(6, 1);
         int bad   = 0;
         clear_logs();
         make_stream(words);
         begin_load(8'(base), 9'(words));
         send_stream(3, $urandom_range(4 * words - 1, 1));
         wait_done(40);
         vectors++;
         if (wq.size() !== words || dq.size() !== 1) begin
            miscompares++;
            $display("FAIL random_count%0d: got %0d writes %0d done, required %0d writes 1 done",
                     it, wq.size(), dq.size(), words);
         end else begin
            for (int i = 0; i < words; i++)
               if (wq[i].addr !== exp_addr(base, i) || wq[i].data !== exp_word(i)) bad++;
            vectors++;
            if (bad != 0) begin
               miscompares++;
               $display("FAIL random_data%0d: got %0d wrong writes, required 0", it, bad);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_wrap();
      test_zero_and_overflow();
      test_full_depth();
      test_reset_mid_load();
      test_random_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_imem_loader
